// File: rtl/maxnet_iterator.sv
// Four-lane MAXNET winner-take-all iterator: lanes inhibit one another until a single
// nonzero activation remains, all die out, or the step cap is reached.
module maxnet_iterator #(
  parameter int unsigned EPS_SHIFT = 3,
  parameter int unsigned MAX_ITER  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  input  logic [31:0] in4,
  input  logic        term_done,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] x3,
  output logic [31:0] x4,
  output logic        o1,
  output logic        o2,
  output logic        o3,
  output logic        o4,
  output logic        busy,
  output logic        result_valid,
  output logic        fail,
  output logic [7:0]  iter_count
);

  localparam int unsigned XW = 32;
  localparam int unsigned SW = 34;
  localparam int unsigned CW = 8;
  localparam int unsigned NL = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q    [NL];
  logic [XW-1:0]      x_d    [NL];
  logic [XW-1:0]      load_x [NL];
  logic [XW-1:0]      step_x [NL];
  logic [XW-1:0]      in_vec [NL];
  logic [CW-1:0]      iter_q, iter_d;
  logic               fail_q, fail_d;
  logic               busy_q, rv_q;
  logic [NL-1:0]      nz_c;
  logic signed [SW-1:0] sum_c;

  assign in_vec = '{in1, in2, in3, in4};

  // Total activation, wide enough that four 31-bit magnitudes cannot overflow.
  assign sum_c = SW'($signed(x_q[0])) + SW'($signed(x_q[1]))
               + SW'($signed(x_q[2])) + SW'($signed(x_q[3]));

  // Per-lane inhibition from the other three lanes, clamped at zero.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic signed [SW-1:0] xe;
    logic signed [SW-1:0] red;
    logic signed [SW-1:0] cand;

    assign xe        = SW'($signed(x_q[i]));
    assign red       = (sum_c - xe) >>> EPS_SHIFT;
    assign cand      = xe - red;
    assign step_x[i] = cand[SW-1] ? '0 : XW'(cand);
    assign load_x[i] = in_vec[i][XW-1] ? '0 : in_vec[i];
    assign nz_c[i]   = |x_q[i];
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    iter_d  = iter_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = load_x;
          iter_d  = '0;
          fail_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (term_done) begin
          fail_d  = 1'b0;
          state_d = DONE;
        end else if (nz_c == '0) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (iter_q == CW'(MAX_ITER)) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else begin
          x_d    = step_x;
          iter_d = iter_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NL; i++) x_q[i] <= '0;
      iter_q  <= '0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      iter_q  <= iter_d;
      fail_q  <= fail_d;
      busy_q  <= (state_d == RUN);
      rv_q    <= (state_d == DONE);
    end
  end

  assign x1           = x_q[0];
  assign x2           = x_q[1];
  assign x3           = x_q[2];
  assign x4           = x_q[3];
  assign o1           = nz_c[0];
  assign o2           = nz_c[1];
  assign o3           = nz_c[2];
  assign o4           = nz_c[3];
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign fail         = fail_q;
  assign iter_count   = iter_q;

endmodule
